sobel_window_ctrl: RTL and testbench
====================================

Name: sobel_window_ctrl

Overview:
Timing controller for the 3x3 Sobel window path. Consumes the window-aligned video control signals from the line buffer stage, tracks the row and column of the newest pixel in the window, and qualifies the window as complete or incomplete. Also emits frame and line strobes and measures frame geometry for the downstream gradient stage and the output formatter.

Parameters:
COL_W, 12, column counter width; must cover max line width (2100)
ROW_W, 12, row counter width
MIN_ROWS, 2, newest-pixel row index from which the window has 3 valid rows
MIN_COLS, 2, newest-pixel column index from which the window has 3 valid columns

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
hsync_in  in  1  hsync aligned with the pixel window
vsync_in  in  1  vsync aligned with the pixel window
de_in  in  1  data enable aligned with the pixel window
col  out  COL_W  column of the newest window pixel in the current line
row  out  ROW_W  row of the newest window pixel in the current frame
win_valid  out  1  window holds 9 real pixels; center is (row-1, col-1)
frame_start  out  1  one-cycle pulse on vsync_in rising edge
line_start  out  1  one-cycle pulse on de_in rising edge inside a frame
line_end  out  1  one-cycle pulse on de_in falling edge inside a frame
width_meas  out  COL_W  pixel count of the last completed line
height_meas  out  ROW_W  active line count of the last completed frame
busy  out  1  high while state is not IDLE

Behaviour:
- Reset is asynchronous and active-low: every register clears. State=IDLE; col, row, width_meas, height_meas=0; all pulses and win_valid=0.
- Edge detection uses one register stage per input. All outputs are registered: 1 cycle latency from input to output.
- FSM states: IDLE, HBLANK, ACTIVE.
- IDLE: ignore de_in and hsync_in. On vsync_in rise, pulse frame_start, go to HBLANK, and clear row and col.
- HBLANK: on de_in rise, pulse line_start, set col=0, go to ACTIVE. On vsync_in rise, latch height_meas=row, pulse frame_start, clear row, and stay in HBLANK.
- ACTIVE: col increments each cycle while de_in=1, saturating at all-ones. On de_in fall, pulse line_end, latch width_meas=col+1, increment row (saturating), and go to HBLANK.
- vsync_in rise during ACTIVE (frame aborted): latch height_meas=row+1, then handle it as a new frame start. Row and col clear, frame_start pulses, state goes to HBLANK, and line_end is not pulsed.
- win_valid = (state ACTIVE) and de_in and row>=MIN_ROWS and col>=MIN_COLS, registered with the col/row it qualifies.
- de_in and vsync_in rising in the same cycle: the frame start is processed first, then the line start, so the line is row 0.
- hsync_in is used only to detect a de_in rise without a preceding hsync. That case is legal and has no effect on behaviour.

Optional Feature:
Macro WIDTH_CHECK_EN.
- Defined: adds output width_err (1 bit, sticky until next frame_start) and an internal reference width. The reference is captured at the line_end of row 0. width_err sets when any later line in the frame ends with a width different from the reference. Reset clears both.
- Not defined: no width_err port and no comparison logic.

Test Plan:
- Reset: hold rst_n=0 mid-line, then release -> all outputs 0, state IDLE, de_in pulses ignored until a vsync rise.
- Frame 8x5: vsync pulse, then 5 lines of 8 de cycles with 4-cycle blanking -> win_valid high 6 cycles/line on rows 2..4 (18 total); width_meas=8 after each line; at next vsync height_meas=5.
- Counters: line of 8 pixels -> col sequence 0..7 one cycle after de; line_start and line_end each pulse once; row 0->1 after line_end.
- Simultaneous vsync and de rise -> frame_start and line_start both pulse; first line has row=0, col=0.
- Abort: vsync rise at col=3 of row 2 -> height_meas=3, row=0, no line_end pulse, state HBLANK.
- WIDTH_CHECK_EN: line widths 8,8,7,8 -> width_err sets after the third line and stays high; clears at the next frame_start.

Source files
------------

// File: rtl/sobel_window_ctrl_if.sv
// sobel_window_ctrl_if: window-aligned video timing in, position/strobes/geometry out.
// width_err exists only when WIDTH_CHECK_EN is defined.
interface sobel_window_ctrl_if #(
  parameter int COL_W = 12,
  parameter int ROW_W = 12
);
  logic hsync_in, vsync_in, de_in;
  logic [COL_W-1:0] col, width_meas;
  logic [ROW_W-1:0] row, height_meas;
  logic win_valid, frame_start, line_start, line_end, busy;
`ifdef WIDTH_CHECK_EN
  logic width_err;
  modport master(output hsync_in, vsync_in, de_in,
                 input col, row, win_valid, frame_start, line_start, line_end,
                 width_meas, height_meas, busy, width_err);
  modport slave(input hsync_in, vsync_in, de_in,
                output col, row, win_valid, frame_start, line_start, line_end,
                width_meas, height_meas, busy, width_err);
`else
  modport master(output hsync_in, vsync_in, de_in,
                 input col, row, win_valid, frame_start, line_start, line_end,
                 width_meas, height_meas, busy);
  modport slave(input hsync_in, vsync_in, de_in,
                output col, row, win_valid, frame_start, line_start, line_end,
                width_meas, height_meas, busy);
`endif
endinterface

// File: rtl/sobel_window_ctrl.sv
// sobel_window_ctrl: tracks newest-pixel row/col, qualifies the 3x3 window, emits frame/line strobes
// and measures frame geometry. WIDTH_CHECK_EN adds a sticky width_err against the row-0 line width.
module sobel_window_ctrl #(
  parameter int COL_W    = 12,
  parameter int ROW_W    = 12,
  parameter int MIN_ROWS = 2,
  parameter int MIN_COLS = 2
) (
  input logic clk,
  input logic rst_n,
  sobel_window_ctrl_if.slave v
);
  typedef enum logic [1:0] {IDLE, HBLANK, ACTIVE} state_t;
  state_t state, state_n;
  logic vs_q, de_q, vs_rise, de_rise, de_fall;
  logic fs_n, ls_n, le_n, win_n;
  logic [COL_W-1:0] col_n, col_inc, width_n;
  logic [ROW_W-1:0] row_n, row_inc, height_n;
  assign vs_rise = v.vsync_in & ~vs_q;
  assign de_rise = v.de_in & ~de_q;
  assign de_fall = ~v.de_in & de_q;
  assign col_inc = &v.col ? v.col : v.col + 1'b1;
  assign row_inc = &v.row ? v.row : v.row + 1'b1;
  assign v.busy  = state != IDLE;
  always_comb begin
    state_n  = state;
    col_n    = v.col;
    row_n    = v.row;
    width_n  = v.width_meas;
    height_n = v.height_meas;
    fs_n     = 1'b0;
    ls_n     = 1'b0;
    le_n     = 1'b0;
    if (vs_rise) begin
      // an aborted line counts toward the measured height; no line_end for it
      height_n = state == ACTIVE ? row_inc : state == HBLANK ? v.row : v.height_meas;
      fs_n     = 1'b1;
      row_n    = '0;
      col_n    = '0;
      state_n  = HBLANK;
      if (de_rise && state != ACTIVE) begin
        ls_n    = 1'b1;
        state_n = ACTIVE;
      end
    end else if (state == HBLANK && de_rise) begin
      ls_n    = 1'b1;
      col_n   = '0;
      state_n = ACTIVE;
    end else if (state == ACTIVE && de_fall) begin
      le_n    = 1'b1;
      width_n = col_inc;
      row_n   = row_inc;
      state_n = HBLANK;
    end else if (state == ACTIVE && v.de_in) begin
      col_n = col_inc;
    end
  end
  assign win_n = state_n == ACTIVE && v.de_in && row_n >= ROW_W'(MIN_ROWS) && col_n >= COL_W'(MIN_COLS);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      vs_q          <= 1'b0;
      de_q          <= 1'b0;
      v.col         <= '0;
      v.row         <= '0;
      v.width_meas  <= '0;
      v.height_meas <= '0;
      v.frame_start <= 1'b0;
      v.line_start  <= 1'b0;
      v.line_end    <= 1'b0;
      v.win_valid   <= 1'b0;
    end else begin
      state         <= state_n;
      vs_q          <= v.vsync_in;
      de_q          <= v.de_in;
      v.col         <= col_n;
      v.row         <= row_n;
      v.width_meas  <= width_n;
      v.height_meas <= height_n;
      v.frame_start <= fs_n;
      v.line_start  <= ls_n;
      v.line_end    <= le_n;
      v.win_valid   <= win_n;
    end
  end
`ifdef WIDTH_CHECK_EN
  logic [COL_W-1:0] ref_width;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_width   <= '0;
      v.width_err <= 1'b0;
    end else if (fs_n) begin
      v.width_err <= 1'b0;
    end else if (le_n && v.row == '0) begin
      ref_width <= width_n;
    end else if (le_n && width_n != ref_width) begin
      v.width_err <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_sobel_window_ctrl.sv
// tb_sobel_window_ctrl: table vectors, directed corner sequences and random video timing
// checked against a pixel/line counting reference model.
module tb_sobel_window_ctrl;
  localparam int CW = 12, RW = 12, CMAX = 4095, RMAX = 4095;
  logic clk = 1'b0, rst_n = 1'b0;
  sobel_window_ctrl_if #(.COL_W(CW), .ROW_W(RW)) vif();
  sobel_window_ctrl #(.COL_W(CW), .ROW_W(RW), .MIN_ROWS(2), .MIN_COLS(2)) dut (
    .clk(clk), .rst_n(rst_n), .v(vif));
  always #5 clk = ~clk;
  int n_tests = 0, n_fail = 0, wins = 0;
  int m_mode, m_pix, m_lines, m_w, m_h, m_ref;
  bit m_pvs, m_pde, m_fs, m_ls, m_le, m_win, m_err;
  typedef struct {
    logic vs, de;
    int col, row;
    logic fs, ls, le, win, busy;
    int w, h;
  } vec_t;
  vec_t tbl[17];
  function automatic int sat(int x, int m);
    return x > m ? m : x;
  endfunction
  task automatic m_reset();
    m_mode = 0; m_pix = 0; m_lines = 0; m_w = 0; m_h = 0; m_ref = 0;
    m_pvs = 0; m_pde = 0; m_fs = 0; m_ls = 0; m_le = 0; m_win = 0; m_err = 0;
  endtask
  // mode 0: waiting for first frame, 1: between lines, 2: inside a line
  task automatic m_step(input bit vs, input bit de);
    bit vr, dr, df;
    vr = vs && !m_pvs; dr = de && !m_pde; df = !de && m_pde;
    m_pvs = vs; m_pde = de;
    m_fs = 0; m_ls = 0; m_le = 0;
    if (vr) begin
      if (m_mode == 2) m_h = sat(m_lines + 1, RMAX);
      else if (m_mode == 1) m_h = sat(m_lines, RMAX);
      m_fs = 1; m_lines = 0; m_pix = 0; m_mode = 1; m_err = 0;
      if (dr) begin m_ls = 1; m_pix = 1; m_mode = 2; end
    end else if (m_mode == 1 && dr) begin
      m_ls = 1; m_pix = 1; m_mode = 2;
    end else if (m_mode == 2 && df) begin
      m_le = 1; m_w = sat(m_pix, CMAX);
      if (m_lines == 0) m_ref = m_w;
      else if (m_w != m_ref) m_err = 1;
      m_lines++; m_mode = 1;
    end else if (m_mode == 2 && de) begin
      m_pix++;
    end
    m_win = m_mode == 2 && de && m_lines >= 2 && m_pix >= 3;
  endtask
  task automatic cyc(input bit vs, input bit de);
    int ec, er;
    bit ge, ee;
    vif.vsync_in = vs; vif.de_in = de; vif.hsync_in = 1'($urandom_range(0, 1));
    @(posedge clk);
    m_step(vs, de);
    @(negedge clk);
    ec = m_pix == 0 ? 0 : sat(m_pix - 1, CMAX);
    er = sat(m_lines, RMAX);
    ge = 0; ee = 0;
`ifdef WIDTH_CHECK_EN
    ge = vif.width_err; ee = m_err;
`endif
    n_tests++;
    if ({vif.col, vif.row, vif.width_meas, vif.height_meas, vif.frame_start, vif.line_start,
         vif.line_end, vif.win_valid, vif.busy, ge} !==
        {CW'(ec), RW'(er), CW'(m_w), RW'(m_h), m_fs, m_ls, m_le, m_win, m_mode != 0, ee}) begin
      n_fail++;
      $display("FAIL model @%0t: got col=%0d row=%0d w=%0d h=%0d fs=%b ls=%b le=%b win=%b busy=%b err=%b; want col=%0d row=%0d w=%0d h=%0d fs=%b ls=%b le=%b win=%b busy=%b err=%b",
               $time, vif.col, vif.row, vif.width_meas, vif.height_meas, vif.frame_start, vif.line_start,
               vif.line_end, vif.win_valid, vif.busy, ge, ec, er, m_w, m_h, m_fs, m_ls, m_le, m_win,
               m_mode != 0, ee);
    end
    wins += int'(vif.win_valid);
  endtask
  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask
  task automatic line(input int n, input int blank);
    repeat (n) cyc(0, 1);
    repeat (blank) cyc(0, 0);
  endtask
  initial begin
    logic [52:0] got, want;
    bit vs, de;
    tbl[0]  = '{0,1, 0,0, 0,0,0,0,0, 0,0};
    tbl[1]  = '{0,0, 0,0, 0,0,0,0,0, 0,0};
    tbl[2]  = '{1,1, 0,0, 1,1,0,0,1, 0,0};
    tbl[3]  = '{1,1, 1,0, 0,0,0,0,1, 0,0};
    tbl[4]  = '{0,1, 2,0, 0,0,0,0,1, 0,0};
    tbl[5]  = '{0,0, 2,1, 0,0,1,0,1, 3,0};
    tbl[6]  = '{0,0, 2,1, 0,0,0,0,1, 3,0};
    tbl[7]  = '{0,1, 0,1, 0,1,0,0,1, 3,0};
    tbl[8]  = '{0,1, 1,1, 0,0,0,0,1, 3,0};
    tbl[9]  = '{0,1, 2,1, 0,0,0,0,1, 3,0};
    tbl[10] = '{0,0, 2,2, 0,0,1,0,1, 3,0};
    tbl[11] = '{0,1, 0,2, 0,1,0,0,1, 3,0};
    tbl[12] = '{0,1, 1,2, 0,0,0,0,1, 3,0};
    tbl[13] = '{0,1, 2,2, 0,0,0,1,1, 3,0};
    tbl[14] = '{0,1, 3,2, 0,0,0,1,1, 3,0};
    tbl[15] = '{0,0, 3,3, 0,0,1,0,1, 4,0};
    tbl[16] = '{1,0, 0,0, 1,0,0,0,1, 4,3};
    vif.vsync_in = 0; vif.de_in = 0; vif.hsync_in = 0;
    m_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
    cyc(1, 0); cyc(0, 0); cyc(0, 1); cyc(0, 1); cyc(0, 1);
    rst_n = 0;
    #1;
    chk("rst_col", int'(vif.col), 0);
    chk("rst_busy", int'(vif.busy), 0);
    chk("rst_line_start", int'(vif.line_start), 0);
    vif.vsync_in = 0; vif.de_in = 0;
    m_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
    foreach (tbl[i]) begin
      cyc(tbl[i].vs, tbl[i].de);
      got  = {vif.col, vif.row, vif.width_meas, vif.height_meas, vif.frame_start, vif.line_start,
              vif.line_end, vif.win_valid, vif.busy};
      want = {CW'(tbl[i].col), RW'(tbl[i].row), CW'(tbl[i].w), RW'(tbl[i].h), tbl[i].fs, tbl[i].ls,
              tbl[i].le, tbl[i].win, tbl[i].busy};
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL vec%0d: got %h, want %h", i, got, want);
      end
    end
    cyc(0, 0); cyc(1, 0);
    chk("frame_start_8x5", int'(vif.frame_start), 1);
    repeat (3) cyc(0, 0);
    wins = 0;
    for (int l = 0; l < 5; l++) begin
      line(8, 4);
      chk("width_8x5", int'(vif.width_meas), 8);
    end
    chk("win_count_8x5", wins, 18);
    cyc(1, 0);
    chk("height_8x5", int'(vif.height_meas), 5);
    cyc(0, 0);
    line(8, 4); line(8, 4);
    repeat (4) cyc(0, 1);
    chk("abort_pre_col", int'(vif.col), 3);
    chk("abort_pre_row", int'(vif.row), 2);
    cyc(1, 1);
    chk("abort_height", int'(vif.height_meas), 3);
    chk("abort_row", int'(vif.row), 0);
    chk("abort_line_end", int'(vif.line_end), 0);
    chk("abort_frame_start", int'(vif.frame_start), 1);
    cyc(0, 0);
    chk("abort_no_line_end", int'(vif.line_end), 0);
    cyc(0, 1);
    chk("abort_hblank_line_start", int'(vif.line_start), 1);
    cyc(0, 0);
`ifdef WIDTH_CHECK_EN
    cyc(1, 0); cyc(0, 0);
    line(8, 3); line(8, 3);
    chk("werr_after_8_8", int'(vif.width_err), 0);
    line(7, 3);
    chk("werr_after_7", int'(vif.width_err), 1);
    line(8, 3);
    chk("werr_sticky", int'(vif.width_err), 1);
    cyc(1, 0);
    chk("werr_clear", int'(vif.width_err), 0);
    cyc(0, 0);
`endif
    vs = 0; de = 0;
    for (int i = 0; i < 4000; i++) begin
      vs = vs ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 5) == 0) de = !de;
      cyc(vs, de);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
